// File: rtl/shop_req_arb_pkg.sv
// rtl/shop_req_arb_pkg.sv - shared constants, ASCII command keys and FSM encoding for shop_req_arb
package shop_req_arb_pkg;

    localparam int I_U_W  = 4;   // shop_v user-id width
    localparam int I_A_W  = 56;  // shop_v command/argument width (7 ASCII chars)
    localparam int O_A_W  = 72;  // shop_v response width (9 ASCII chars)
    localparam int IDX_W  = 3;   // client index width (up to 8 clients)
    localparam int CNT_W  = 8;   // setup / response-wait counter width
    localparam int TO_W   = 16;  // lock idle-timeout counter width

    // Command keywords, right-aligned and zero-padded on the left
    localparam logic [I_A_W-1:0] CMD_KEY__LOGIN   = 56'h0000_4C6F_6769_6E;
    localparam logic [I_A_W-1:0] CMD_KEY__LOGOUT  = 56'h00_4C6F_676F_7574;
    localparam logic [I_A_W-1:0] CMD_KEY__ADDUSR  = 56'h00_4164_6455_7372;
    localparam logic [I_A_W-1:0] CMD_KEY__DELUSR  = 56'h00_4465_6C55_7372;
    localparam logic [I_A_W-1:0] CMD_KEY__ADDITEM = 56'h4164_6449_7465_6D;
    localparam logic [I_A_W-1:0] CMD_KEY__DELITEM = 56'h4465_6C49_7465_6D;
    localparam logic [I_A_W-1:0] CMD_KEY__BUY     = 56'h0000_0000_4275_79;
    localparam logic [I_A_W-1:0] CMD_KEY__NONE    = '0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/shop_req_arb_rr_arb.sv
// rtl/shop_req_arb_rr_arb.sv - combinational round-robin pick over an eligibility mask
// Ports:
//   i_mask     eligible requesters
//   i_ptr      highest-priority index this round
//   o_gnt_oh   one-hot winner (0 when nothing eligible)
//   o_gnt_idx  winner index
//   o_any      some requester is eligible
module shop_req_arb_rr_arb
    import shop_req_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] i_mask,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt_oh,
    output logic [IDX_W-1:0]   o_gnt_idx,
    output logic               o_any
);

    // First pass scans ptr..NUM_REQ-1, second pass wraps to 0..ptr-1.
    always_comb begin
        o_gnt_oh  = '0;
        o_gnt_idx = '0;
        o_any     = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!o_any && (j >= int'(i_ptr)) && i_mask[j]) begin
                o_any       = 1'b1;
                o_gnt_idx   = IDX_W'(j);
                o_gnt_oh[j] = 1'b1;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!o_any && (j < int'(i_ptr)) && i_mask[j]) begin
                o_any       = 1'b1;
                o_gnt_idx   = IDX_W'(j);
                o_gnt_oh[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shop_req_arb.sv
// rtl/shop_req_arb.sv - shares the shop_v command port among NUM_REQ clients with session locking
// Ports:
//   i_clk, i_reset           clock, async active-high reset
//   i_req/i_req_u/i_req_a    per-client request level, user id, ASCII word
//   o_gnt                    one-cycle pulse: request captured
//   o_rsp_vld/o_rsp_a        one-cycle response pulse per client, captured response
//   o_shop_rdy/u/a, i_shop_a shop_v handshake
//   o_lock/o_lock_owner      session lock state
module shop_req_arb
    import shop_req_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int I_U_NUM_BITS = 4,
    parameter int I_A_NUM_BITS = 56,
    parameter int O_A_NUM_BITS = 72,
    parameter int SETUP_CYC    = 1,
    parameter int RESP_WAIT    = 4,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic [NUM_REQ-1:0]                i_req,
    input  logic [NUM_REQ*I_U_NUM_BITS-1:0]   i_req_u,
    input  logic [NUM_REQ*I_A_NUM_BITS-1:0]   i_req_a,
    output logic [NUM_REQ-1:0]                o_gnt,
    output logic [NUM_REQ-1:0]                o_rsp_vld,
    output logic [O_A_NUM_BITS-1:0]           o_rsp_a,
    output logic                              o_shop_rdy,
    output logic [I_U_NUM_BITS-1:0]           o_shop_u,
    output logic [I_A_NUM_BITS-1:0]           o_shop_a,
    input  logic [O_A_NUM_BITS-1:0]           i_shop_a,
    output logic                              o_lock,
    output logic [2:0]                        o_lock_owner
);

    state_t                    r_state;
    logic [NUM_REQ-1:0]        r_gnt;
    logic [NUM_REQ-1:0]        r_rsp_vld;
    logic [O_A_NUM_BITS-1:0]   r_rsp_a;
    logic                      r_shop_rdy;
    logic [I_U_NUM_BITS-1:0]   r_shop_u;
    logic [I_A_NUM_BITS-1:0]   r_shop_a;
    logic                      r_lock;
    logic [IDX_W-1:0]          r_owner;
    logic [IDX_W-1:0]          r_ptr;
    logic [IDX_W-1:0]          r_cur;
    logic                      r_logout_pend;
    logic [CNT_W-1:0]          r_cnt;
    logic [TO_W-1:0]           r_to_cnt;

    logic [NUM_REQ-1:0]        w_owner_oh;
    logic                      w_owner_req;
    logic [NUM_REQ-1:0]        w_elig;
    logic [NUM_REQ-1:0]        w_gnt_oh;
    logic [IDX_W-1:0]          w_gnt_idx;
    logic                      w_any;
    logic [I_U_NUM_BITS-1:0]   w_sel_u;
    logic [I_A_NUM_BITS-1:0]   w_sel_a;
    logic                      w_is_login;
    logic                      w_is_logout;
    logic                      w_grant;

    always_comb begin
        w_owner_oh  = '0;
        w_owner_req = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (r_owner == IDX_W'(j)) begin
                w_owner_oh[j] = 1'b1;
                w_owner_req   = i_req[j];
            end
        end
    end

    // While a session is open only its owner may issue.
    assign w_elig = r_lock ? (i_req & w_owner_oh) : i_req;

    shop_req_arb_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arb (
        .i_mask    (w_elig),
        .i_ptr     (r_ptr),
        .o_gnt_oh  (w_gnt_oh),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    always_comb begin
        w_sel_u = '0;
        w_sel_a = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_gnt_oh[j]) begin
                w_sel_u = i_req_u[j*I_U_NUM_BITS +: I_U_NUM_BITS];
                w_sel_a = i_req_a[j*I_A_NUM_BITS +: I_A_NUM_BITS];
            end
        end
    end

    assign w_is_login  = (w_sel_a == I_A_NUM_BITS'(CMD_KEY__LOGIN));
    assign w_is_logout = (w_sel_a == I_A_NUM_BITS'(CMD_KEY__LOGOUT));

    // DONE also arbitrates so back-to-back commands issue every 7 cycles.
    assign w_grant = w_any && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_gnt         <= '0;
            r_rsp_vld     <= '0;
            r_rsp_a       <= '0;
            r_shop_rdy    <= 1'b0;
            r_shop_u      <= '0;
            r_shop_a      <= '0;
            r_lock        <= 1'b0;
            r_owner       <= '0;
            r_ptr         <= '0;
            r_cur         <= '0;
            r_logout_pend <= 1'b0;
            r_cnt         <= '0;
            r_to_cnt      <= '0;
        end else begin
            r_gnt     <= '0;
            r_rsp_vld <= '0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_grant) begin
                        r_gnt         <= w_gnt_oh;
                        r_shop_u      <= w_sel_u;
                        r_shop_a      <= w_sel_a;
                        r_cur         <= w_gnt_idx;
                        r_ptr         <= (w_gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : w_gnt_idx + IDX_W'(1);
                        r_cnt         <= '0;
                        r_state       <= ST_SETUP;
                        r_logout_pend <= r_lock && w_is_logout;
                        if (r_lock) begin
                            // only the owner can be granted while locked
                            r_to_cnt <= '0;
                        end else if (w_is_login) begin
                            r_lock   <= 1'b1;
                            r_owner  <= w_gnt_idx;
                            r_to_cnt <= '0;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        if ((r_state == ST_IDLE) && r_lock && !w_owner_req && (LOCK_TIMEOUT != 0)) begin
                            if (r_to_cnt == TO_W'(LOCK_TIMEOUT-1)) begin
                                r_lock   <= 1'b0;
                                r_to_cnt <= '0;
                            end else begin
                                r_to_cnt <= r_to_cnt + TO_W'(1);
                            end
                        end
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == CNT_W'(SETUP_CYC-1)) begin
                        r_state    <= ST_STROBE;
                        r_shop_rdy <= 1'b1;
                        r_cnt      <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_STROBE: begin
                    r_shop_rdy <= 1'b0;
                    r_state    <= ST_WAIT;
                    r_cnt      <= '0;
                end
                ST_WAIT: begin
                    if (r_cnt == CNT_W'(RESP_WAIT-1)) begin
                        r_state   <= ST_DONE;
                        r_rsp_a   <= i_shop_a;
                        r_rsp_vld <= NUM_REQ'(1) << r_cur;
                        if (r_logout_pend) begin
                            r_lock        <= 1'b0;
                            r_to_cnt      <= '0;
                            r_logout_pend <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_gnt        = r_gnt;
    assign o_rsp_vld    = r_rsp_vld;
    assign o_rsp_a      = r_rsp_a;
    assign o_shop_rdy   = r_shop_rdy;
    assign o_shop_u     = r_shop_u;
    assign o_shop_a     = r_shop_a;
    assign o_lock       = r_lock;
    assign o_lock_owner = r_owner;

endmodule

// File: tb/tb_shop_req_arb.sv
// tb/tb_shop_req_arb.sv - self-checking bench for shop_req_arb
module tb_shop_req_arb;

    localparam int N  = 4;
    localparam int UW = 4;
    localparam int AW = 56;
    localparam int RW = 72;

    localparam logic [AW-1:0] K_LOGIN   = 56'h0000_4C6F_6769_6E;
    localparam logic [AW-1:0] K_LOGOUT  = 56'h00_4C6F_676F_7574;
    localparam logic [AW-1:0] K_ADDUSR  = 56'h00_4164_6455_7372;
    localparam logic [AW-1:0] K_DELUSR  = 56'h00_4465_6C55_7372;
    localparam logic [AW-1:0] K_ADDITEM = 56'h4164_6449_7465_6D;
    localparam logic [AW-1:0] K_DELITEM = 56'h4465_6C49_7465_6D;
    localparam logic [AW-1:0] K_BUY     = 56'h0000_0000_4275_79;
    localparam logic [RW-1:0] R_ITEMOK  = 72'h0000_4974_656D_204F_4B;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*UW-1:0]   req_u;
    logic [N*AW-1:0]   req_a;
    logic [N-1:0]      o_gnt;
    logic [N-1:0]      o_rsp_vld;
    logic [RW-1:0]     o_rsp_a;
    logic              o_shop_rdy;
    logic [UW-1:0]     o_shop_u;
    logic [AW-1:0]     o_shop_a;
    logic [RW-1:0]     shop_in;
    logic              o_lock;
    logic [2:0]        o_lock_owner;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int last_gnt_cyc = 0;

    typedef struct {
        int            c;
        logic [RW-1:0] rsp;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int            c;
        logic [UW-1:0] u;
        logic [AW-1:0] a;
        logic          lk;
    } vec_t;
    vec_t vecs[6];

    // Stand-in for shop_v: canned reply for AddItem, otherwise echo word and user.
    function automatic logic [RW-1:0] shop_resp(input logic [UW-1:0] u, input logic [AW-1:0] a);
        if (a == K_ADDITEM) return R_ITEMOK;
        return {a, 12'h000, u};
    endfunction

    assign shop_in = shop_resp(o_shop_u, o_shop_a);

    shop_req_arb dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_req        (req),
        .i_req_u      (req_u),
        .i_req_a      (req_a),
        .o_gnt        (o_gnt),
        .o_rsp_vld    (o_rsp_vld),
        .o_rsp_a      (o_rsp_a),
        .o_shop_rdy   (o_shop_rdy),
        .o_shop_u     (o_shop_u),
        .o_shop_a     (o_shop_a),
        .i_shop_a     (shop_in),
        .o_lock       (o_lock),
        .o_lock_owner (o_lock_owner)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (o_gnt != '0) last_gnt_cyc = cyc;
        if (o_rsp_vld != '0) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 128'(o_rsp_vld), 128'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_vld", 128'(o_rsp_vld), 128'(1) << e.c);
                chk("rsp_a", 128'(o_rsp_a), 128'(e.rsp));
                chk("rsp_latency", 128'(cyc - last_gnt_cyc), 128'(6));
            end
        end
    end

    task automatic set_client(input int c, input logic [UW-1:0] u, input logic [AW-1:0] a, input logic on);
        req_u[c*UW +: UW] = u;
        req_a[c*AW +: AW] = a;
        req[c]            = on;
    endtask

    task automatic push(input int c, input logic [UW-1:0] u, input logic [AW-1:0] a);
        exp_t e;
        e.c   = c;
        e.rsp = shop_resp(u, a);
        sb.push_back(e);
    endtask

    task automatic wait_gnt(input int budget, input string name, output int gc);
        int n;
        n = 0;
        @(negedge clk);
        while (o_gnt == '0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (o_gnt == '0) chk({name, "_timeout"}, 128'(0), 128'(1));
        gc = cyc;
    endtask

    task automatic do_txn(input int c, input logic [UW-1:0] u, input logic [AW-1:0] a);
        int d;
        int g;
        logic [6:0] hist;
        set_client(c, u, a, 1'b1);
        push(c, u, a);
        d = cyc;
        wait_gnt(20, "txn_gnt", g);
        chk("txn_gnt", 128'(o_gnt), 128'(1) << c);
        chk("txn_gnt_lat", 128'(g - d), 128'(1));
        chk("txn_shop_u", 128'(o_shop_u), 128'(u));
        chk("txn_shop_a", 128'(o_shop_a), 128'(a));
        req[c] = 1'b0;
        hist = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            hist[k] = o_shop_rdy;
        end
        chk("txn_rdy_window", 128'(hist), 128'(7'b0000010));
        chk("txn_shop_a_held", 128'(o_shop_a), 128'(a));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g;
        int g2;
        int g3;

        vecs[0] = '{0, 4'h0, K_ADDITEM, 1'b0};
        vecs[1] = '{0, 4'h0, K_LOGOUT,  1'b0};
        vecs[2] = '{3, 4'h5, K_DELUSR,  1'b0};
        vecs[3] = '{1, 4'h7, K_ADDUSR,  1'b0};
        vecs[4] = '{2, 4'hF, K_DELITEM, 1'b0};
        vecs[5] = '{3, 4'h9, K_BUY,     1'b0};

        rst   = 1'b1;
        req   = '0;
        req_u = '0;
        req_a = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 128'(o_gnt), 128'(0));
        chk("rst_rsp_vld", 128'(o_rsp_vld), 128'(0));
        chk("rst_rsp_a", 128'(o_rsp_a), 128'(0));
        chk("rst_rdy", 128'(o_shop_rdy), 128'(0));
        chk("rst_shop_u", 128'(o_shop_u), 128'(0));
        chk("rst_shop_a", 128'(o_shop_a), 128'(0));
        chk("rst_lock", 128'(o_lock), 128'(0));
        chk("rst_owner", 128'(o_lock_owner), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        // single transactions; ends with pointer back at 0
        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i].c, vecs[i].u, vecs[i].a);
            chk("tbl_lock", 128'(o_lock), 128'(vecs[i].lk));
        end

        // three simultaneous requests from pointer 0
        set_client(0, 4'h1, K_BUY, 1'b1);
        set_client(1, 4'h2, K_ADDUSR, 1'b1);
        set_client(2, 4'h3, K_DELUSR, 1'b1);
        push(0, 4'h1, K_BUY);
        push(1, 4'h2, K_ADDUSR);
        push(2, 4'h3, K_DELUSR);
        wait_gnt(20, "rr_a", g);
        chk("rr_a_gnt", 128'(o_gnt), 128'(4'b0001));
        req[0] = 1'b0;
        wait_gnt(20, "rr_b", g2);
        chk("rr_b_gnt", 128'(o_gnt), 128'(4'b0010));
        chk("rr_b_period", 128'(g2 - g), 128'(7));
        req[1] = 1'b0;
        wait_gnt(20, "rr_c", g3);
        chk("rr_c_gnt", 128'(o_gnt), 128'(4'b0100));
        chk("rr_c_period", 128'(g3 - g2), 128'(7));
        req[2] = 1'b0;
        // pointer now 3: client 3 must beat client 1
        set_client(1, 4'h4, K_ADDITEM, 1'b1);
        set_client(3, 4'h5, K_DELITEM, 1'b1);
        push(3, 4'h5, K_DELITEM);
        push(1, 4'h4, K_ADDITEM);
        wait_gnt(20, "rr_d", g);
        chk("rr_d_gnt", 128'(o_gnt), 128'(4'b1000));
        req[3] = 1'b0;
        wait_gnt(20, "rr_e", g2);
        chk("rr_e_gnt", 128'(o_gnt), 128'(4'b0010));
        req[1] = 1'b0;
        repeat (6) @(negedge clk);

        // session lock held by client 1 until its Logout completes
        do_txn(1, 4'h2, K_LOGIN);
        chk("lk_lock_on", 128'(o_lock), 128'(1));
        chk("lk_owner", 128'(o_lock_owner), 128'(1));
        set_client(0, 4'h0, K_BUY, 1'b1);
        set_client(1, 4'h2, K_BUY, 1'b1);
        push(1, 4'h2, K_BUY);
        push(1, 4'h2, K_LOGOUT);
        push(0, 4'h0, K_BUY);
        wait_gnt(20, "lk_buy", g);
        chk("lk_buy_gnt", 128'(o_gnt), 128'(4'b0010));
        chk("lk_buy_a", 128'(o_shop_a), 128'(K_BUY));
        set_client(1, 4'h2, K_LOGOUT, 1'b1);
        wait_gnt(20, "lk_logout", g2);
        chk("lk_logout_gnt", 128'(o_gnt), 128'(4'b0010));
        chk("lk_logout_a", 128'(o_shop_a), 128'(K_LOGOUT));
        chk("lk_logout_period", 128'(g2 - g), 128'(7));
        req[1] = 1'b0;
        while (cyc < g2 + 5) @(negedge clk);
        chk("lk_still_locked", 128'(o_lock), 128'(1));
        @(negedge clk);
        chk("lk_released", 128'(o_lock), 128'(0));
        wait_gnt(20, "lk_c0", g3);
        chk("lk_c0_gnt", 128'(o_gnt), 128'(4'b0001));
        chk("lk_c0_lat", 128'(g3 - g2), 128'(7));
        req[0] = 1'b0;
        repeat (6) @(negedge clk);

        // idle timeout releases client 2's session
        set_client(2, 4'h3, K_LOGIN, 1'b1);
        push(2, 4'h3, K_LOGIN);
        wait_gnt(20, "to_login", g);
        chk("to_login_gnt", 128'(o_gnt), 128'(4'b0100));
        req[2] = 1'b0;
        set_client(3, 4'h4, K_ADDUSR, 1'b1);
        push(3, 4'h4, K_ADDUSR);
        while (cyc < g + 22) @(negedge clk);
        chk("to_locked", 128'(o_lock), 128'(1));
        chk("to_owner", 128'(o_lock_owner), 128'(2));
        @(negedge clk);
        chk("to_released", 128'(o_lock), 128'(0));
        wait_gnt(30, "to_c3", g2);
        chk("to_c3_gnt", 128'(o_gnt), 128'(4'b1000));
        chk("to_c3_lat", 128'(g2 - g), 128'(24));
        req[3] = 1'b0;
        repeat (6) @(negedge clk);

        // reset in WAIT drops the response and lock; pointer returns to 0
        set_client(1, 4'h1, K_LOGIN, 1'b1);
        wait_gnt(20, "rs_login", g);
        chk("rs_login_gnt", 128'(o_gnt), 128'(4'b0010));
        req[1] = 1'b0;
        while (cyc < g + 3) @(negedge clk);
        chk("rs_locked_before", 128'(o_lock), 128'(1));
        rst = 1'b1;
        #1;
        chk("rs_rdy", 128'(o_shop_rdy), 128'(0));
        chk("rs_lock", 128'(o_lock), 128'(0));
        chk("rs_shop_a", 128'(o_shop_a), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("rs_lock_after", 128'(o_lock), 128'(0));
        set_client(0, 4'h6, K_BUY, 1'b1);
        set_client(3, 4'h7, K_DELITEM, 1'b1);
        push(0, 4'h6, K_BUY);
        push(3, 4'h7, K_DELITEM);
        wait_gnt(20, "rs_c0", g);
        chk("rs_c0_gnt", 128'(o_gnt), 128'(4'b0001));
        req[0] = 1'b0;
        wait_gnt(20, "rs_c3", g2);
        chk("rs_c3_gnt", 128'(o_gnt), 128'(4'b1000));
        req[3] = 1'b0;
        repeat (10) @(negedge clk);

        chk("sb_drained", 128'(sb.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
